// File: rtl/crossing_monitor_if.sv
// Sample input and trace-drain handshake bundle for crossing_monitor.
// master drives samples and trace_ready; slave is the monitor.
interface crossing_monitor_if;
  logic       in_valid;
  logic [1:0] missionary_in;
  logic [1:0] cannibal_in;
  logic       direction_in;
  logic       trace_ready;
  logic       trace_valid;
  logic [4:0] trace_data;

  modport master (
    output in_valid, missionary_in, cannibal_in, direction_in,
    output trace_ready,
    input  trace_valid, trace_data
  );

  modport slave (
    input  in_valid, missionary_in, cannibal_in, direction_in,
    input  trace_ready,
    output trace_valid, trace_data
  );
endinterface

// File: rtl/crossing_monitor.sv
// River-crossing transition checker with trace FIFO and step counter.
// Define CROSSING_MONITOR_SAFETY_EN to include the bank-safety check.
module crossing_monitor #(
  parameter int DEPTH  = 8,
  parameter int STEP_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  crossing_monitor_if.slave bus,
  output logic [STEP_W-1:0] step_count,
  output logic              finish,
  output logic              illegal,
  output logic              overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;

  state_t state_q, state_d;
  logic [4:0] prev_q, prev_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic fin_q, fin_d;
  logic ill_q, ill_d;
  logic ovf_q, ovf_d;
  logic [4:0] mem_q [DEPTH];
  logic [4:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic [4:0] data_q, data_d;

  logic [4:0] smp;
  logic [1:0] m, c, pm, pc;
  logic d, pd;
  logic [1:0] dm, dc;
  logic [2:0] moved;
  logic mono, safe, legal;
  logic push, step_inc, fin_set, ill_set;
  logic pop, full, push_ok, drop;

  assign smp = {bus.direction_in, bus.missionary_in, bus.cannibal_in};
  assign d   = smp[4];
  assign m   = smp[3:2];
  assign c   = smp[1:0];
  assign pd  = prev_q[4];
  assign pm  = prev_q[3:2];
  assign pc  = prev_q[1:0];

  // Boat leaving the start bank removes people; returning adds them.
  always_comb begin
    mono = 1'b1;
    dm   = '0;
    dc   = '0;
    if (pd) begin
      mono = (m <= pm) && (c <= pc);
      dm   = pm - m;
      dc   = pc - c;
    end else begin
      mono = (m >= pm) && (c >= pc);
      dm   = m - pm;
      dc   = c - pc;
    end
    moved = {1'b0, dm} + {1'b0, dc};
  end

`ifdef CROSSING_MONITOR_SAFETY_EN
  logic [1:0] fm, fc;
  assign fm   = 2'd3 - m;
  assign fc   = 2'd3 - c;
  assign safe = ((m == 2'd0) || (m >= c)) &&
                ((fm == 2'd0) || (fm >= fc));
`else
  assign safe = 1'b1;
`endif

  assign legal = (d != pd) && mono && safe &&
                 ((moved == 3'd1) || (moved == 3'd2));

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    push     = 1'b0;
    step_inc = 1'b0;
    fin_set  = 1'b0;
    ill_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (smp == 5'b1_11_11) begin
            prev_d  = smp;
            push    = 1'b1;
            state_d = RUN;
          end else begin
            ill_set = 1'b1;
            state_d = ERROR;
          end
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          if (legal) begin
            prev_d   = smp;
            push     = 1'b1;
            step_inc = 1'b1;
            if (smp == 5'b0) begin
              fin_set = 1'b1;
              state_d = DONE;
            end
          end else begin
            ill_set = 1'b1;
            state_d = ERROR;
          end
        end
      end
      default: ;
    endcase
  end

  assign pop     = valid_q & bus.trace_ready;
  assign full    = (cnt_q == FULL);
  assign push_ok = push && (!full || pop);
  assign drop    = push && !push_ok;

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wptr_q] = smp;
    wptr_d  = wptr_q + PW'(push_ok);
    rptr_d  = rptr_q + PW'(pop);
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);
    valid_d = (cnt_d != '0);
    data_d  = valid_d ? mem_d[rptr_d] : 5'd0;
    step_d  = (step_inc && (step_q != '1)) ? step_q + 1'b1 : step_q;
    fin_d   = fin_q | fin_set;
    ill_d   = ill_q | ill_set;
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      step_q  <= '0;
      fin_q   <= 1'b0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      step_q  <= step_d;
      fin_q   <= fin_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.trace_valid = valid_q;
  assign bus.trace_data  = data_q;
  assign step_count      = step_q;
  assign finish          = fin_q;
  assign illegal         = ill_q;
  assign overflow        = ovf_q;

endmodule
